mac_accum_seq: RTL and testbench

- Parametrised, sequential successor to the combinational 4-bit multiply-accumulate block.
- Multiplies an A_W-bit unsigned operand by a B_W-bit unsigned operand with a radix-2 shift-add datapath, one multiplier bit per cycle.
- Adds each product into an internal ACC_W-bit accumulator across a group of operations.
- Upstream uses a valid/ready handshake for operands; downstream uses a valid/ready handshake for the accumulated result. Intended as the per-lane MAC engine of the AI-chip datapath.

---
 rtl/mac_accum_seq.sv | 167 ++++++++++++++++
 tb/tb_mac_accum_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_seq.sv
// mac_accum_seq: sequential multiply-accumulate engine (one lane).
//
// Multiplies an unsigned A_W-bit operand by an unsigned B_W-bit operand with a
// radix-2 shift-add datapath (one multiplier bit per cycle), then adds the
// product into an ACC_W-bit accumulator. A group of operations is opened by
// 'clr' and closed by 'last'; the group result is offered downstream with a
// valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operand handshake; a, b, clr, last sampled on transfer
//   a [A_W]           multiplicand
//   b [B_W]           multiplier
//   clr               op starts a new group (acc and ovf treated as 0)
//   last              op ends the group; result is emitted afterwards
//   out_valid/out_ready result handshake
//   acc_out [ACC_W]   accumulator value (meaningful while out_valid)
//   ovf               sticky accumulator carry-out within the group
//
// Optional build macro:
//   MAC_ACC_SAT_EN    accumulator saturates at all-ones instead of wrapping.
//
// Timing: accept at edge k, MUL steps on edges k+1..k+B_W, ACC on edge
// k+B_W+1, so the next operand (or the result handshake) can transfer at
// edge k+B_W+2.

module mac_accum_seq #(
    parameter int A_W   = 4,
    parameter int B_W   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             clr,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    generate
        if (ACC_W < A_W + B_W) begin : g_width_check
            $error("mac_accum_seq: ACC_W must be >= A_W + B_W");
        end
    endgenerate

    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   a_sh;
    logic [B_W-1:0]     b_sh;
    logic [ACC_W-1:0]   prod;
    logic [ACC_W-1:0]   acc;
    logic               ovf_r;
    logic               clr_r;
    logic               last_r;
    logic [CNT_W-1:0]   cnt;

    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_nxt;

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                // rst gates in_ready so nothing is advertised during reset
                in_ready = !rst;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                // fixed latency: no early exit when the multiplier empties
                if (cnt == CNT_LAST) state_nxt = ACC;
            end
            ACC: begin
                state_nxt = last_r ? DONE : IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Accumulate step: one extra bit catches the carry-out
    // ------------------------------------------------------------------
    always_comb begin
        acc_base = clr_r ? {ACC_W{1'b0}} : acc;
        sum      = {1'b0, acc_base} + {1'b0, prod};
`ifdef MAC_ACC_SAT_EN
        acc_nxt  = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_nxt  = sum[ACC_W-1:0];
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            prod   <= '0;
            acc    <= '0;
            ovf_r  <= 1'b0;
            clr_r  <= 1'b0;
            last_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= ACC_W'(a);
                        b_sh   <= b;
                        clr_r  <= clr;
                        last_r <= last;
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (b_sh[0]) prod <= prod + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                end
                ACC: begin
                    acc   <= acc_nxt;
                    ovf_r <= (clr_r ? 1'b0 : ovf_r) | sum[ACC_W];
                end
                DONE: begin
                    // result consumed: the next group starts from zero
                    if (out_ready) begin
                        acc   <= '0;
                        ovf_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_out = acc;
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_mac_accum_seq.sv
// tb_mac_accum_seq: self-checking bench for mac_accum_seq (default parameters).
// Expected group results are queued when the closing op is driven and popped
// by a monitor on each result handshake.

module tb_mac_accum_seq;

    localparam int A_W   = 4;
    localparam int B_W   = 4;
    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             clr;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    mac_accum_seq #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A_W-1:0]   a;
        logic [B_W-1:0]   b;
        logic             clr;
        logic             last;
        logic [ACC_W-1:0] exp_acc;
        logic             exp_ovf;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int acc_v, input logic ovf_v);
        res_t r;
        r.acc = ACC_W'(acc_v);
        r.ovf = ovf_v;
        sb.push_back(r);
    endtask

    // Result monitor: compares every downstream transfer with the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got acc=%0d with no result pending", acc_out);
            end else begin
                res_t r;
                r = sb.pop_front();
                check("result_acc", int'(acc_out), int'(r.acc));
                check("result_ovf", int'(ovf), int'(r.ovf));
            end
        end
    end

    // Drives one op and returns on the negedge after it was accepted.
    task automatic send_op(input int av, input int bv, input logic c, input logic l);
        int n = 0;
        a = A_W'(av); b = B_W'(bv); clr = c; last = l;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    vec_t tbl[8];
    int   prev_cyc;
    logic prev_last;
    int   lat;

    initial begin
        tbl[0] = '{a: 15, b: 15, clr: 1, last: 1, exp_acc: 225, exp_ovf: 0};
        tbl[1] = '{a: 3,  b: 4,  clr: 1, last: 0, exp_acc: 0,   exp_ovf: 0};
        tbl[2] = '{a: 5,  b: 6,  clr: 0, last: 0, exp_acc: 0,   exp_ovf: 0};
        tbl[3] = '{a: 7,  b: 8,  clr: 0, last: 1, exp_acc: 98,  exp_ovf: 0};
        tbl[4] = '{a: 0,  b: 9,  clr: 1, last: 1, exp_acc: 0,   exp_ovf: 0};
        tbl[5] = '{a: 9,  b: 0,  clr: 1, last: 0, exp_acc: 0,   exp_ovf: 0};
        tbl[6] = '{a: 6,  b: 7,  clr: 0, last: 1, exp_acc: 42,  exp_ovf: 0};
        tbl[7] = '{a: 1,  b: 15, clr: 1, last: 1, exp_acc: 15,  exp_ovf: 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; clr = 1'b0; last = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_acc_out", int'(acc_out), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);

        // ---- latency of a single-op group ----
        push_exp(225, 1'b0);
        send_op(15, 15, 1'b1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        // high on the (B_W+1)th negedge => transferable at edge k+B_W+2
        check("out_valid_latency", lat, B_W + 1);
        wait_drain();

        // ---- table-driven groups, with in_ready spacing inside groups ----
        prev_last = 1'b1;
        prev_cyc  = 0;
        foreach (tbl[i]) begin
            if (tbl[i].last) push_exp(int'(tbl[i].exp_acc), tbl[i].exp_ovf);
            send_op(int'(tbl[i].a), int'(tbl[i].b), tbl[i].clr, tbl[i].last);
            if (!prev_last) check("accept_spacing", acc_cyc - prev_cyc, B_W + 2);
            prev_cyc  = acc_cyc;
            prev_last = tbl[i].last;
            if (tbl[i].last) wait_drain();
        end

        // ---- 19 x 15*15 = 4275 overflows a 12-bit accumulator ----
`ifdef MAC_ACC_SAT_EN
        push_exp(4095, 1'b1);
`else
        push_exp(179, 1'b1);
`endif
        for (int i = 0; i < 19; i++) send_op(15, 15, i == 0, i == 18);
        wait_drain();

        // ---- clr op after an overflowed group starts clean ----
        push_exp(6, 1'b0);
        send_op(2, 3, 1'b1, 1'b1);
        wait_drain();

        // ---- backpressure in DONE ----
        out_ready = 1'b0;
        push_exp(12, 1'b0);
        send_op(3, 4, 1'b1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_reached_done", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_acc_out", int'(acc_out), 12);
            check("bp_in_ready", int'(in_ready), 0);
            a = 4'd9; b = 4'd9; clr = 1'b1; last = 1'b1;
            in_valid = (i % 2) == 0;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);
        check("bp_ignored_ops_out_valid", int'(out_valid), 0);
        check("bp_ignored_ops_in_ready", int'(in_ready), 1);
        wait_drain();

        // ---- reset during MUL cycle 2 discards the group ----
        send_op(5, 5, 1'b1, 1'b0);
        send_op(1, 1, 1'b0, 1'b1);
        check("mid_group_acc", int'(acc_out), 25);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mulrst_out_valid", int'(out_valid), 0);
        check("mulrst_acc_out", int'(acc_out), 0);
        check("mulrst_ovf", int'(ovf), 0);
        check("mulrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mulrst_release_in_ready", int'(in_ready), 1);
        push_exp(1, 1'b0);
        send_op(1, 1, 1'b1, 1'b1);
        wait_drain();

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
